dotmatrix_scan_ctrl: RTL and testbench
======================================

Name: dotmatrix_scan_ctrl

Overview:
- Double-buffered scan controller for the 8x8 LED dot matrix.
- Owns two 8-row frame buffers. Accepts row writes into the back buffer over a valid/ready handshake, and swaps buffers only at frame boundaries so no frame is shown torn.
- Time-multiplexes the front buffer onto Row_LED/Col_LED, one column slot at a time, with a programmable blanking interval that suppresses ghosting.
- Sits between pattern/character logic (writer) and the matrix pins.

Parameters:
- SCAN_DIV, 27000, clock cycles per column slot; minimum 4.
- BLANK_CYC, 200, cycles at the start of each slot with all LEDs off; must be < SCAN_DIV.
- CNT_W, 25, width of the slot cycle counter; must hold SCAN_DIV-1.

Ports:
- CLK  in  1  system clock.
- RESET  in  1  asynchronous, active-high reset.
- enable  in  1  scan enable; low = display blanked and scan frozen.
- wr_valid  in  1  row-write request.
- wr_ready  out  1  controller can accept a write.
- wr_addr  in  3  back-buffer row index.
- wr_data  in  8  row pattern; 1 = LED on.
- swap_req  in  1  one-cycle pulse: present the back buffer at the next frame end.
- swap_ack  out  1  one-cycle pulse: swap performed.
- frame_start  out  1  one-cycle pulse when the scan wraps slot 7 -> 0.
- Row_LED  out  8  active-low row drive: ~pattern.
- Col_LED  out  8  one-hot column select: 1 << slot.

Behaviour:
- Reset values:
  - rCnt=0, slot=0, front_sel=0, swap_pending=0.
  - Both buffers all-zero.
  - Row_LED=8'hFF, Col_LED=8'h00, swap_ack=0, frame_start=0, wr_ready=1.
- Slot counter:
  - While enable=1, rCnt counts 0..SCAN_DIV-1 and wraps.
  - tick = enable & (rCnt==SCAN_DIV-1).
  - On tick, slot increments; 7 wraps to 0.
- enable=0:
  - rCnt and slot are held.
  - Outputs forced to blank (Row_LED=FF, Col_LED=00).
  - Writes are still accepted; swaps are deferred.
- Display outputs (registered, one-cycle latency from rCnt/slot):
  - If rCnt < BLANK_CYC: Row_LED=FF, Col_LED=00.
  - Otherwise: Col_LED = 8'b1<<slot, Row_LED = ~front[slot].
- Write handshake:
  - wr_ready = ~swap_pending.
  - A write occurs on the cycle where wr_valid & wr_ready: back[wr_addr] <= wr_data.
  - wr_data/wr_addr are ignored when not accepted; the writer holds them until ready.
- Swap FSM, two states:
  - IDLE: swap_req -> PENDING. If that same cycle is also a tick with slot==7, swap immediately instead.
  - PENDING: on a tick with slot==7, toggle front_sel, pulse swap_ack the next cycle, return to IDLE.
  - swap_req while in PENDING is ignored; no queueing and no extra ack.
- Simultaneous write and swap_req in IDLE: the write is accepted into the old back buffer, so it is visible after the swap.
- frame_start: pulses the cycle after the tick with slot==7, coincident with a swap_ack if a swap occurs.
- RESET asserted mid-frame or mid-pending:
  - Immediate return to reset values.
  - The pending swap is discarded and no swap_ack is issued.
- Back-buffer contents after a swap are the old front frame, not cleared.

Test Plan:
Bench parameters for all scenarios: SCAN_DIV=8, BLANK_CYC=2.
1. Reset release, enable=1, no writes:
   - Col_LED steps 01,02,...,80,01, each held 6 cycles after 2 blank cycles.
   - Row_LED stays FF throughout.
   - frame_start every 64 cycles.
2. Write rows 0..7 = 8'h3C, then swap_req mid slot 3:
   - wr_ready=0 until the frame end; swap_ack 1 cycle after the slot-7 tick.
   - From the next frame, Row_LED=8'hC3 in every non-blank window.
3. swap_req on the exact slot-7 tick cycle:
   - Swap at that tick; swap_ack next cycle.
   - wr_ready never drops for a full frame.
4. Second swap_req while pending, plus wr_valid held high:
   - Only one swap_ack.
   - The write completes on the cycle after the swap, into the new back buffer.
5. enable low for 20 cycles in slot 4:
   - Outputs FF/00 throughout; slot and rCnt frozen.
   - On enable high, resumes slot 4 at the same rCnt.
6. RESET pulse during PENDING:
   - Outputs return to FF/00, wr_ready=1, no swap_ack.
   - Display stays blank, since the buffers are zeroed.

Source files
------------

// File: rtl/dotmatrix_scan_ctrl_if.sv
// Writer-side bus of the dot-matrix scan controller: row-write handshake plus
// the buffer-swap request/acknowledge pair.
interface dotmatrix_scan_ctrl_if;
    logic       wr_valid;
    logic       wr_ready;
    logic [2:0] wr_addr;
    logic [7:0] wr_data;
    logic       swap_req;
    logic       swap_ack;

    modport master (
        output wr_valid, wr_addr, wr_data, swap_req,
        input  wr_ready, swap_ack
    );

    modport slave (
        input  wr_valid, wr_addr, wr_data, swap_req,
        output wr_ready, swap_ack
    );
endinterface

// File: rtl/dotmatrix_scan_ctrl.sv
// Double-buffered 8x8 LED matrix scanner: rows are written into the back frame,
// the front frame is column-multiplexed onto the pins with a per-slot blanking gap.
//
// state     | meaning
// S_IDLE    | no swap outstanding, writes accepted
// S_PENDING | swap requested, waiting for the slot-7 tick; writes stalled
module dotmatrix_scan_ctrl #(
    parameter int SCAN_DIV  = 27000,
    parameter int BLANK_CYC = 200,
    parameter int CNT_W     = 25
) (
    input  logic                 CLK,
    input  logic                 RESET,
    input  logic                 enable,
    dotmatrix_scan_ctrl_if.slave wr,
    output logic                 frame_start,
    output logic [7:0]           Row_LED,
    output logic [7:0]           Col_LED
);

    typedef enum logic [0:0] {
        S_IDLE    = 1'b0,
        S_PENDING = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic             w_do_swap;

    logic [CNT_W-1:0] r_cnt;
    logic [2:0]       r_slot;
    logic             r_front_sel;
    logic [7:0]       r_buf [2][8];
    logic             r_swap_ack;
    logic             r_frame_start;
    logic [7:0]       r_row;
    logic [7:0]       r_col;

    logic             w_tick;
    logic             w_frame_end;
    logic             w_wr_fire;

    assign w_tick      = enable && (r_cnt == CNT_W'(SCAN_DIV - 1));
    assign w_frame_end = w_tick && (r_slot == 3'd7);
    assign wr.wr_ready = (r_state == S_IDLE);
    assign w_wr_fire   = wr.wr_valid && wr.wr_ready;

    assign wr.swap_ack = r_swap_ack;
    assign frame_start = r_frame_start;
    assign Row_LED     = r_row;
    assign Col_LED     = r_col;

    // A request landing on the frame-end tick swaps at once instead of waiting a frame.
    always_comb begin
        w_state_nxt = r_state;
        w_do_swap   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (wr.swap_req) begin
                    if (w_frame_end) w_do_swap   = 1'b1;
                    else             w_state_nxt = S_PENDING;
                end
            end
            S_PENDING: begin
                if (w_frame_end) begin
                    w_do_swap   = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_state       <= S_IDLE;
            r_swap_ack    <= 1'b0;
            r_frame_start <= 1'b0;
            r_front_sel   <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_swap_ack    <= w_do_swap;
            r_frame_start <= w_frame_end;
            if (w_do_swap) r_front_sel <= ~r_front_sel;
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_cnt  <= '0;
            r_slot <= 3'd0;
        end else if (enable) begin
            if (w_tick) begin
                r_cnt  <= '0;
                r_slot <= r_slot + 3'd1;
            end else begin
                r_cnt  <= r_cnt + CNT_W'(1);
            end
        end
    end

    // Writes index the back frame with the pre-swap select, so a write coinciding
    // with a swap lands in the frame that is about to become visible.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            for (int i = 0; i < 8; i++) begin
                r_buf[0][i] <= 8'h00;
                r_buf[1][i] <= 8'h00;
            end
        end else if (w_wr_fire) begin
            r_buf[~r_front_sel][wr.wr_addr] <= wr.wr_data;
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_row <= 8'hFF;
            r_col <= 8'h00;
        end else if (!enable || (r_cnt < CNT_W'(BLANK_CYC))) begin
            r_row <= 8'hFF;
            r_col <= 8'h00;
        end else begin
            r_col <= 8'b1 << r_slot;
            r_row <= ~r_buf[r_front_sel][r_slot];
        end
    end

endmodule

// File: tb/tb_dotmatrix_scan_ctrl.sv
// Self-checking bench for dotmatrix_scan_ctrl with a frame-position reference model.
module tb_dotmatrix_scan_ctrl;
    localparam int SD = 8;
    localparam int BL = 2;
    localparam int FR = 8 * SD;

    logic       CLK    = 1'b0;
    logic       RESET  = 1'b0;
    logic       enable = 1'b0;
    logic       frame_start;
    logic [7:0] Row_LED;
    logic [7:0] Col_LED;

    dotmatrix_scan_ctrl_if bus ();

    dotmatrix_scan_ctrl #(.SCAN_DIV(SD), .BLANK_CYC(BL), .CNT_W(3)) dut (
        .CLK        (CLK),
        .RESET      (RESET),
        .enable     (enable),
        .wr         (bus.slave),
        .frame_start(frame_start),
        .Row_LED    (Row_LED),
        .Col_LED    (Col_LED)
    );

    always #5 CLK = ~CLK;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    // Reference model: one position 0..63 through the frame, two frame arrays that
    // physically trade places on a swap.
    int         m_pos;
    bit         m_pending;
    logic [7:0] m_front [8];
    logic [7:0] m_back  [8];
    logic [7:0] m_tmp   [8];
    logic [7:0] e_row = 8'hFF;
    logic [7:0] e_col = 8'h00;
    bit         e_ack, e_fs;

    always @(posedge CLK or posedge RESET) begin : model
        int slot;
        bit fe, sw, fire;
        if (RESET) begin
            m_pos = 0; m_pending = 0; e_row = 8'hFF; e_col = 8'h00; e_ack = 0; e_fs = 0;
            for (int i = 0; i < 8; i++) begin m_front[i] = 8'h00; m_back[i] = 8'h00; end
        end else begin
            slot = m_pos / SD;
            fire = bus.wr_valid && !m_pending;
            fe   = enable && (m_pos == FR - 1);
            if (!enable || (m_pos % SD) < BL) begin
                e_row = 8'hFF; e_col = 8'h00;
            end else begin
                e_col = 8'(1 << slot); e_row = ~m_front[slot];
            end
            sw = fe && (m_pending || bus.swap_req);
            if (fire) m_back[bus.wr_addr] = bus.wr_data;
            if (sw) begin
                m_tmp = m_front; m_front = m_back; m_back = m_tmp;
                m_pending = 0;
            end else if (bus.swap_req) begin
                m_pending = 1;
            end
            e_ack = sw;
            e_fs  = fe;
            if (enable) m_pos = (m_pos + 1) % FR;
        end
    end

    task automatic step();
        @(negedge CLK);
        cyc++;
    endtask

    task automatic test_reset();
        RESET = 1'b1; enable = 1'b1;
        bus.wr_valid = 1'b0; bus.wr_addr = 3'd0; bus.wr_data = 8'h00; bus.swap_req = 1'b0;
        repeat (2) step();
        tests++;
        if ({Row_LED, Col_LED, bus.swap_ack, frame_start, bus.wr_ready} !== {8'hFF, 8'h00, 1'b0, 1'b0, 1'b1}) begin
            fails++;
            $display("FAIL reset: got row=%h col=%h ack=%b fs=%b rdy=%b want FF/00/0/0/1",
                     Row_LED, Col_LED, bus.swap_ack, frame_start, bus.wr_ready);
        end
        RESET = 1'b0;
    endtask

    task automatic test_scan();
        int last_fs = -1;
        int seen_fs = 0;
        for (int k = 1; k <= 140; k++) begin
            int p;
            logic [7:0] exp_col;
            step();
            p = (k - 1) % FR;
            exp_col = ((p % SD) < BL) ? 8'h00 : 8'(1 << (p / SD));
            tests++;
            if (Row_LED !== 8'hFF || Col_LED !== exp_col) begin
                fails++;
                $display("FAIL scan_pattern k=%0d: got row=%h col=%h want FF/%h", k, Row_LED, Col_LED, exp_col);
            end
            tests++;
            if ({Row_LED, Col_LED, bus.swap_ack, frame_start, bus.wr_ready} !== {e_row, e_col, e_ack, e_fs, ~m_pending}) begin
                fails++;
                $display("FAIL scan_model cyc=%0d: got %h/%h/%b/%b/%b want %h/%h/%b/%b/%b", cyc, Row_LED, Col_LED,
                         bus.swap_ack, frame_start, bus.wr_ready, e_row, e_col, e_ack, e_fs, ~m_pending);
            end
            if (frame_start) begin
                if (last_fs >= 0) begin
                    tests++;
                    if (k - last_fs != FR) begin
                        fails++;
                        $display("FAIL frame_period: got %0d want %0d", k - last_fs, FR);
                    end
                end
                last_fs = k;
                seen_fs++;
            end
        end
        tests++;
        if (seen_fs != 2) begin
            fails++;
            $display("FAIL frame_start_count: got %0d want 2", seen_fs);
        end
    endtask

    task automatic test_swap_mid();
        int lit = 0;
        bit got_ack = 0;
        for (int a = 0; a < 8; a++) begin
            bus.wr_valid = 1'b1; bus.wr_addr = 3'(a); bus.wr_data = 8'h3C;
            step();
        end
        bus.wr_valid = 1'b0;
        for (int n = 0; n < 2 * FR && m_pos != 3 * SD + 4; n++) step();
        tests++;
        if (m_pos != 3 * SD + 4) begin fails++; $display("FAIL swap_mid_wait: got pos %0d want %0d", m_pos, 3 * SD + 4); end
        bus.swap_req = 1'b1;
        step();
        bus.swap_req = 1'b0;
        for (int n = 0; n < 200 && !got_ack; n++) begin
            tests++;
            if ({Row_LED, Col_LED, bus.swap_ack, frame_start, bus.wr_ready} !== {e_row, e_col, e_ack, e_fs, ~m_pending}) begin
                fails++;
                $display("FAIL swap_mid_model cyc=%0d: got %h/%h/%b/%b/%b want %h/%h/%b/%b/%b", cyc, Row_LED, Col_LED,
                         bus.swap_ack, frame_start, bus.wr_ready, e_row, e_col, e_ack, e_fs, ~m_pending);
            end
            if (bus.swap_ack) begin
                got_ack = 1;
                tests++;
                if (frame_start !== 1'b1) begin fails++; $display("FAIL swap_ack_with_fs: got fs=%b want 1", frame_start); end
            end else begin
                tests++;
                if (bus.wr_ready !== 1'b0) begin fails++; $display("FAIL ready_low_pending: got %b want 0", bus.wr_ready); end
                step();
            end
        end
        tests++;
        if (!got_ack) begin fails++; $display("FAIL swap_mid_timeout: got no ack want ack"); end
        for (int n = 0; n < FR; n++) begin
            step();
            tests++;
            if (Col_LED !== 8'h00 && Row_LED !== 8'hC3) begin
                fails++;
                $display("FAIL swap_mid_row: got %h want C3 at col %h", Row_LED, Col_LED);
            end
            if (Col_LED !== 8'h00) lit++;
        end
        tests++;
        if (lit != 8 * (SD - BL)) begin fails++; $display("FAIL lit_count: got %0d want %0d", lit, 8 * (SD - BL)); end
    endtask

    task automatic test_swap_on_tick();
        for (int a = 0; a < 8; a++) begin
            bus.wr_valid = 1'b1; bus.wr_addr = 3'(a); bus.wr_data = 8'($urandom);
            step();
        end
        bus.wr_valid = 1'b0;
        for (int n = 0; n < 2 * FR && m_pos != FR - 1; n++) step();
        tests++;
        if (m_pos != FR - 1 || bus.wr_ready !== 1'b1) begin
            fails++; $display("FAIL tick_wait: got pos %0d rdy %b want %0d/1", m_pos, bus.wr_ready, FR - 1);
        end
        bus.swap_req = 1'b1;
        step();
        bus.swap_req = 1'b0;
        tests++;
        if ({bus.swap_ack, frame_start} !== 2'b11) begin
            fails++; $display("FAIL tick_swap_ack: got ack=%b fs=%b want 1/1", bus.swap_ack, frame_start);
        end
        for (int n = 0; n < FR; n++) begin
            step();
            tests++;
            if (bus.wr_ready !== 1'b1 || bus.swap_ack !== 1'b0 ||
                {Row_LED, Col_LED, frame_start} !== {e_row, e_col, e_fs}) begin
                fails++;
                $display("FAIL tick_frame cyc=%0d: got rdy=%b ack=%b %h/%h/%b want 1/0 %h/%h/%b", cyc, bus.wr_ready,
                         bus.swap_ack, Row_LED, Col_LED, frame_start, e_row, e_col, e_fs);
            end
        end
    endtask

    task automatic test_pending_double();
        int acks = 0;
        int fire_at = -1;
        for (int n = 0; n < 2 * FR && m_pos != 10; n++) step();
        bus.swap_req = 1'b1; step(); bus.swap_req = 1'b0;
        repeat (5) step();
        bus.swap_req = 1'b1; step(); bus.swap_req = 1'b0;
        bus.wr_valid = 1'b1; bus.wr_addr = 3'($urandom_range(7)); bus.wr_data = 8'($urandom);
        for (int n = 0; n < 150; n++) begin
            step();
            tests++;
            if ({Row_LED, Col_LED, bus.swap_ack, frame_start, bus.wr_ready} !== {e_row, e_col, e_ack, e_fs, ~m_pending}) begin
                fails++;
                $display("FAIL pend_model cyc=%0d: got %h/%h/%b/%b/%b want %h/%h/%b/%b/%b", cyc, Row_LED, Col_LED,
                         bus.swap_ack, frame_start, bus.wr_ready, e_row, e_col, e_ack, e_fs, ~m_pending);
            end
            if (bus.swap_ack) acks++;
            if (fire_at < 0 && bus.wr_valid && bus.wr_ready) begin
                fire_at = n;
                tests++;
                if (bus.swap_ack !== 1'b1) begin fails++; $display("FAIL pend_write_timing: got ack=%b want 1", bus.swap_ack); end
            end else if (fire_at >= 0) begin
                bus.wr_valid = 1'b0;
            end
        end
        bus.wr_valid = 1'b0;
        tests++;
        if (acks != 1 || fire_at < 0) begin fails++; $display("FAIL pend_acks: got acks=%0d fire=%0d want 1/>=0", acks, fire_at); end
        for (int n = 0; n < 2 * FR && m_pos != 5; n++) step();
        bus.swap_req = 1'b1; step(); bus.swap_req = 1'b0;
        for (int n = 0; n < 2 * FR; n++) begin
            step();
            tests++;
            if ({Row_LED, Col_LED, bus.swap_ack, frame_start, bus.wr_ready} !== {e_row, e_col, e_ack, e_fs, ~m_pending}) begin
                fails++;
                $display("FAIL pend_show cyc=%0d: got %h/%h/%b want %h/%h/%b", cyc, Row_LED, Col_LED, bus.swap_ack,
                         e_row, e_col, e_ack);
            end
        end
    endtask

    task automatic test_enable_low();
        int lit = 0;
        for (int n = 0; n < 2 * FR && m_pos != 4 * SD + 4; n++) step();
        enable = 1'b0;
        for (int n = 0; n < 20; n++) begin
            step();
            tests++;
            if (Row_LED !== 8'hFF || Col_LED !== 8'h00 || bus.wr_ready !== 1'b1) begin
                fails++; $display("FAIL en_low_blank: got %h/%h rdy=%b want FF/00/1", Row_LED, Col_LED, bus.wr_ready);
            end
        end
        enable = 1'b1;
        for (int n = 0; n < 6; n++) begin
            step();
            if (n == 0) begin
                tests++;
                if (Col_LED !== 8'h10) begin fails++; $display("FAIL en_resume_col: got %h want 10", Col_LED); end
            end
            tests++;
            if ({Row_LED, Col_LED, frame_start} !== {e_row, e_col, e_fs}) begin
                fails++; $display("FAIL en_resume_model: got %h/%h want %h/%h", Row_LED, Col_LED, e_row, e_col);
            end
            if (Col_LED === 8'h10) lit++;
        end
        tests++;
        if (lit != 4) begin fails++; $display("FAIL en_resume_len: got %0d want 4", lit); end
    endtask

    task automatic test_reset_pending();
        for (int n = 0; n < 2 * FR && m_pos != 12; n++) step();
        bus.swap_req = 1'b1; step(); bus.swap_req = 1'b0;
        repeat (3) step();
        tests++;
        if (bus.wr_ready !== 1'b0) begin fails++; $display("FAIL rst_pend_setup: got rdy=%b want 0", bus.wr_ready); end
        RESET = 1'b1;
        #1;
        tests++;
        if ({Row_LED, Col_LED, bus.swap_ack, frame_start, bus.wr_ready} !== {8'hFF, 8'h00, 1'b0, 1'b0, 1'b1}) begin
            fails++;
            $display("FAIL rst_pend_async: got %h/%h/%b/%b/%b want FF/00/0/0/1", Row_LED, Col_LED, bus.swap_ack,
                     frame_start, bus.wr_ready);
        end
        step();
        RESET = 1'b0;
        for (int n = 0; n < FR + 6; n++) begin
            step();
            tests++;
            if (bus.swap_ack !== 1'b0 || Row_LED !== 8'hFF || bus.wr_ready !== 1'b1) begin
                fails++; $display("FAIL rst_pend_after: got ack=%b row=%h rdy=%b want 0/FF/1", bus.swap_ack, Row_LED, bus.wr_ready);
            end
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 800; n++) begin
            step();
            tests++;
            if ({Row_LED, Col_LED, bus.swap_ack, frame_start, bus.wr_ready} !== {e_row, e_col, e_ack, e_fs, ~m_pending}) begin
                fails++;
                $display("FAIL random cyc=%0d: got %h/%h/%b/%b/%b want %h/%h/%b/%b/%b", cyc, Row_LED, Col_LED,
                         bus.swap_ack, frame_start, bus.wr_ready, e_row, e_col, e_ack, e_fs, ~m_pending);
            end
            enable       = ($urandom_range(15) != 0);
            bus.swap_req = ($urandom_range(39) == 0);
            if (!(bus.wr_valid && !bus.wr_ready)) begin
                bus.wr_valid = 1'($urandom);
                bus.wr_addr  = 3'($urandom);
                bus.wr_data  = 8'($urandom);
            end
        end
        bus.wr_valid = 1'b0; bus.swap_req = 1'b0; enable = 1'b1;
    endtask

    initial begin
        #1;
        test_reset();
        test_scan();
        test_swap_mid();
        test_swap_on_tick();
        test_pending_double();
        test_enable_low();
        test_reset_pending();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
